instruction_fetcher: RTL
========================

Name: instruction_fetcher

Overview:
- Front-end stage directly upstream of the memory controller.
- Holds the architectural fetch PC and issues one instruction fetch at a time over the controller's fetch_start/pc/finish_fetch/instruction_out handshake.
- Applies static next-PC prediction: JAL is taken, everything else goes to pc+4.
- Buffers fetched instructions in a circular instruction queue that the decoder drains; the ROB can redirect it on misprediction.

Parameters:
IQ_ADDR_BITS, 4, log2 of queue depth (depth 16)
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous, active-low reset
rdy_in  input  1  pause when low; all state frozen, outputs held
fetch_start  output  1  fetch request to memory controller
pc  output  32  fetch address to memory controller
finish_fetch  input  1  one-cycle pulse, instruction_out valid
instruction_out  input  32  fetched instruction word
iq_valid  output  1  queue head valid
iq_inst  output  32  head instruction
iq_pc  output  32  head instruction address
iq_pred_pc  output  32  predicted next PC for head
iq_ready  input  1  decoder accepts head this cycle
flush  input  1  ROB misprediction redirect
flush_pc  input  32  redirect target

Behaviour:
- Reset (rst_in low, async): state IDLE; fetch_start=0; pc=RESET_PC; next_pc=RESET_PC; head=tail=count=0; iq_valid=0; iq_inst/iq_pc/iq_pred_pc=0.
- rdy_in low: no register changes; a finish_fetch pulse arriving while rdy_in is low is not captured (the controller is also paused).
- States:
  - IDLE: if count < depth, go to WAIT. On the same edge, pc<=next_pc and fetch_start<=1. At most one fetch is outstanding, so one free slot always suffices.
  - WAIT: fetch_start and pc are held stable until finish_fetch.
    - On finish_fetch: push {instruction_out, pc, pred}; next_pc<=pred; fetch_start<=0; go to IDLE. The minimum gap between requests is 1 cycle low.
  - DISCARD: entered from WAIT on flush; fetch_start and pc are held. The in-flight controller access cannot be aborted.
    - On finish_fetch: drop the word; fetch_start<=0; go to IDLE.
- Prediction: pred = pc + sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}) when inst[6:0]==7'b1101111 (JAL). Otherwise pred = pc+4. Arithmetic is 32-bit modulo with no overflow detection.
- Queue:
  - Circular buffer of 2^IQ_ADDR_BITS entries; head/tail wrap modulo depth.
  - count is IQ_ADDR_BITS+1 bits wide.
  - Pop when iq_valid && iq_ready. Push and pop in the same cycle leave count unchanged.
  - iq_valid = (count != 0). iq_* outputs show entry[head] combinationally.
  - A push never occurs when full, by the IDLE gating.
- Flush (sampled when rdy_in high; highest priority):
  - Queue cleared: head=tail=count=0. A same-cycle push or pop is ignored.
  - next_pc<=flush_pc.
  - IDLE: stays IDLE; the next request uses flush_pc on the following edge.
  - WAIT without finish_fetch: go to DISCARD.
  - WAIT with finish_fetch in the same cycle: drop the word; fetch_start<=0; go to IDLE.
  - DISCARD: stays DISCARD; the latest flush_pc wins.
- Latency: a flush raised on cycle N gives fetch_start high with pc=flush_pc at N+2 when the unit was in IDLE. In-order: instructions pop in fetch order.

Test Plan:
- Reset with RESET_PC=0, then finish_fetch responds 5 cycles after each request with NOPs (32'h00000013), iq_ready=1 -> pc sequence 0,4,8,C; iq_pc follows the same order; iq_pred_pc = iq_pc+4.
- Fetch at pc=0x100 returns 32'h0080006F (JAL +8) -> iq_pred_pc=0x108; next fetch pc=0x108.
- iq_ready=0 with 20 fetches offered -> exactly 16 entries pushed; fetch_start stays low once count=16; a single pop restarts fetching with one new request.
- flush with flush_pc=0x200 during WAIT at pc=0x40 -> DISCARD; the 0x40 word is not queued; iq_valid=0; next request pc=0x200.
- flush coincident with finish_fetch and with iq_ready=1 -> word dropped; count=0; next request pc=flush_pc.
- rdy_in held low 3 cycles mid-WAIT -> pc, fetch_start and queue unchanged; after rdy_in rises, finish_fetch completes normally. rst_in pulsed low asynchronously mid-WAIT -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/instruction_fetcher_if.sv
// Fetch-side bus bundle: memory-controller fetch handshake plus the
// instruction-queue head presented to the decoder.
interface instruction_fetcher_if;
  logic        fetch_start;
  logic [31:0] pc;
  logic        finish_fetch;
  logic [31:0] instruction_out;
  logic        iq_valid;
  logic [31:0] iq_inst;
  logic [31:0] iq_pc;
  logic [31:0] iq_pred_pc;
  logic        iq_ready;

  // Fetcher side.
  modport master (
    output fetch_start, pc, iq_valid, iq_inst, iq_pc, iq_pred_pc,
    input  finish_fetch, instruction_out, iq_ready
  );

  // Memory controller / decoder side.
  modport slave (
    input  fetch_start, pc, iq_valid, iq_inst, iq_pc, iq_pred_pc,
    output finish_fetch, instruction_out, iq_ready
  );
endinterface

// File: rtl/instruction_fetcher.sv
// Instruction fetcher: issues one fetch at a time, predicts JAL targets
// statically, and buffers fetched words in a circular queue for the decoder.
module instruction_fetcher #(
  parameter int unsigned IQ_ADDR_BITS = 4,
  parameter logic [31:0] RESET_PC     = 32'h0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic [31:0]           flush_pc,
  instruction_fetcher_if.master bus
);

  localparam int unsigned Depth = 1 << IQ_ADDR_BITS;
  localparam logic [IQ_ADDR_BITS:0] DepthC = (IQ_ADDR_BITS + 1)'(Depth);

  typedef enum logic [1:0] {StIdle, StWait, StDiscard} state_e;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pred;
  } iq_entry_t;

  state_e                  state_q, state_d;
  logic                    fetch_start_q, fetch_start_d;
  logic [31:0]             pc_q, pc_d;
  logic [31:0]             next_pc_q, next_pc_d;
  logic [IQ_ADDR_BITS-1:0] head_q, head_d, tail_q, tail_d;
  logic [IQ_ADDR_BITS:0]   count_q, count_d;
  iq_entry_t               mem_q [Depth];

  logic        push, pop;
  logic [31:0] jal_imm, pred;

  // Static prediction: JAL taken, everything else falls through.
  assign jal_imm = {{11{bus.instruction_out[31]}}, bus.instruction_out[31],
                    bus.instruction_out[19:12], bus.instruction_out[20],
                    bus.instruction_out[30:21], 1'b0};
  assign pred = (bus.instruction_out[6:0] == 7'b1101111) ? pc_q + jal_imm : pc_q + 32'd4;

  assign bus.fetch_start = fetch_start_q;
  assign bus.pc          = pc_q;
  assign bus.iq_valid    = (count_q != '0);
  assign bus.iq_inst     = mem_q[head_q].inst;
  assign bus.iq_pc       = mem_q[head_q].pc;
  assign bus.iq_pred_pc  = mem_q[head_q].pred;

  // Fetch FSM next state; flush overrides the redirect target last.
  always_comb begin
    state_d       = state_q;
    fetch_start_d = fetch_start_q;
    pc_d          = pc_q;
    next_pc_d     = next_pc_q;
    push          = 1'b0;
    if (rdy_in) begin
      unique case (state_q)
        StIdle: begin
          // One outstanding fetch, so a single free slot is enough.
          if (!flush && (count_q < DepthC)) begin
            state_d       = StWait;
            pc_d          = next_pc_q;
            fetch_start_d = 1'b1;
          end
        end
        StWait: begin
          if (bus.finish_fetch) begin
            fetch_start_d = 1'b0;
            state_d       = StIdle;
            if (!flush) begin
              push      = 1'b1;
              next_pc_d = pred;
            end
          end else if (flush) begin
            state_d = StDiscard;
          end
        end
        StDiscard: begin
          // The controller access cannot be aborted; swallow its result.
          if (bus.finish_fetch) begin
            fetch_start_d = 1'b0;
            state_d       = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
      if (flush) begin
        next_pc_d = flush_pc;
      end
    end
  end

  assign pop = rdy_in && !flush && bus.iq_valid && bus.iq_ready;

  // Queue pointer and occupancy update; flush clears everything.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in && flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) begin
        tail_d = tail_q + 1'b1;
      end
      if (pop) begin
        head_d = head_q + 1'b1;
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  // State, PC and queue-pointer registers.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q       <= StIdle;
      fetch_start_q <= 1'b0;
      pc_q          <= RESET_PC;
      next_pc_q     <= RESET_PC;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
    end else if (rdy_in) begin
      state_q       <= state_d;
      fetch_start_q <= fetch_start_d;
      pc_q          <= pc_d;
      next_pc_q     <= next_pc_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
    end
  end

  // Queue storage; cleared on reset so the empty head reads as zero.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[tail_q] <= '{inst: bus.instruction_out, pc: pc_q, pred: pred};
    end
  end

endmodule
